// File: rtl/inter_master_tx_if.sv
// Bundle between one inter_master_tx instance and its requester / interconnect port.
// Ports: requester push channel (req_valid/req_ready/req_data), interconnect master
// inputs (in_valid/data_out), slave handshake pulses, and status (busy/done_cnt/timeout_err/clr_err).
interface inter_master_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_data;
  logic       in_valid;
  logic [6:0] data_out;
  logic       handshake_slave1;
  logic       handshake_slave2;
  logic       busy;
  logic [7:0] done_cnt;
  logic       timeout_err;
  logic       clr_err;

  // The transmitter itself.
  modport master (
    input  req_valid, req_data, handshake_slave1, handshake_slave2, clr_err,
    output req_ready, in_valid, data_out, busy, done_cnt, timeout_err
  );

  // The requester / interconnect side driving the transmitter.
  modport slave (
    output req_valid, req_data, handshake_slave1, handshake_slave2, clr_err,
    input  req_ready, in_valid, data_out, busy, done_cnt, timeout_err
  );
endinterface

// File: rtl/inter_master_tx.sv
// Initiator-side transmitter: queues requester writes and presents them to one `inter` master port.
// Latency: push at edge k -> in_valid at edge k+1; retire on addressed-slave handshake or TIMEOUT.
// Backpressure: req_ready = !full (DEPTH entries); a 1-cycle in_valid=0 gap separates transactions.
// Ports: clk, rst_n (async active-low), bus (inter_master_tx_if.master: req_*, in_valid,
// data_out, handshake_slave1/2, busy, done_cnt, timeout_err, clr_err).
module inter_master_tx #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inter_master_tx_if.master     bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Request FIFO
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [6:0]    head;

  // Transmit state
  logic [1:0]    state;
  logic [WW-1:0] wait_cnt;
  logic          in_valid_q;
  logic [6:0]    data_q;
  logic [7:0]    done_q;
  logic          err_q;
  logic          match;
  logic          retire_ok;
  logic          retire_to;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.req_valid && !full;
  assign head  = mem[rd_ptr];

  // Only the handshake for the slave addressed by the in-flight request counts.
  assign match     = data_q[6] ? bus.handshake_slave2 : bus.handshake_slave1;
  assign retire_ok = (state == S_SEND) && match;
  // A match on the last allowed SEND cycle takes precedence over the timeout.
  assign retire_to = (state == S_SEND) && !match && (wait_cnt == WAIT_LAST);
  assign pop       = retire_ok || retire_to;

  assign bus.req_ready   = !full;
  assign bus.busy        = !empty || (state != S_IDLE);
  assign bus.in_valid    = in_valid_q;
  assign bus.data_out    = data_q;
  assign bus.done_cnt    = done_q;
  assign bus.timeout_err = err_q;

  // Storage has no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.req_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      in_valid_q <= 1'b0;
      data_q     <= '0;
      done_q     <= '0;
    end else begin
      case (state)
        S_IDLE, S_GAP: begin
          // The head is sampled after any pop of the previous entry has settled.
          if (!empty) begin
            state      <= S_SEND;
            in_valid_q <= 1'b1;
            data_q     <= head;
            wait_cnt   <= '0;
          end else begin
            state      <= S_IDLE;
          end
        end
        S_SEND: begin
          if (retire_ok) begin
            done_q     <= done_q + 8'd1;
            in_valid_q <= 1'b0;
            state      <= S_GAP;
          end else if (retire_to) begin
            in_valid_q <= 1'b0;
            state      <= S_GAP;
          end else begin
            wait_cnt   <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          in_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky drop indication; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (retire_to) begin
      err_q <= 1'b1;
    end else if (bus.clr_err) begin
      err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inter_master_tx.sv
// Directed bench for inter_master_tx: vector table for basic transfers plus
// hand sequences for full FIFO, timeout, boundary, counter wrap and reset.
module tb_inter_master_tx;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  inter_master_tx_if bus ();

  inter_master_tx #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rv;
    logic [6:0] rd;
    logic       h1;
    logic       h2;
    logic       clr;
    logic       ev;
    logic [6:0] ed;
    logic       erdy;
    logic       ebusy;
    logic [7:0] edone;
    logic       eerr;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mkv(logic rv, logic [6:0] rd, logic h1, logic h2, logic clr,
                               logic ev, logic [6:0] ed, logic erdy, logic ebusy,
                               logic [7:0] edone, logic eerr);
    vec_t v;
    v.rv = rv; v.rd = rd; v.h1 = h1; v.h2 = h2; v.clr = clr;
    v.ev = ev; v.ed = ed; v.erdy = erdy; v.ebusy = ebusy; v.edone = edone; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req_valid        = 1'b0;
    bus.req_data         = 7'h00;
    bus.handshake_slave1 = 1'b0;
    bus.handshake_slave2 = 1'b0;
    bus.clr_err          = 1'b0;
  endtask

  task automatic push1(input logic [6:0] d);
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    step();
    bus.req_valid = 1'b0;
    bus.req_data  = 7'h00;
  endtask

  logic [7:0] exp_done;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_in();

    // Single write, wrong-slave, back-to-back and both-handshakes vectors.
    tbl[0]  = mkv(1, 7'h2B, 0, 0, 0,  0, 7'h00, 1, 1, 8'd0, 0);
    tbl[1]  = mkv(0, 7'h00, 0, 0, 0,  1, 7'h2B, 1, 1, 8'd0, 0);
    tbl[2]  = mkv(0, 7'h00, 0, 0, 0,  1, 7'h2B, 1, 1, 8'd0, 0);
    tbl[3]  = mkv(0, 7'h00, 0, 0, 0,  1, 7'h2B, 1, 1, 8'd0, 0);
    tbl[4]  = mkv(0, 7'h00, 1, 0, 0,  0, 7'h2B, 1, 1, 8'd1, 0);
    tbl[5]  = mkv(0, 7'h00, 0, 0, 0,  0, 7'h2B, 1, 0, 8'd1, 0);
    tbl[6]  = mkv(1, 7'h56, 0, 0, 0,  0, 7'h2B, 1, 1, 8'd1, 0);
    tbl[7]  = mkv(0, 7'h00, 0, 0, 0,  1, 7'h56, 1, 1, 8'd1, 0);
    tbl[8]  = mkv(0, 7'h00, 1, 0, 0,  1, 7'h56, 1, 1, 8'd1, 0);
    tbl[9]  = mkv(0, 7'h00, 0, 0, 0,  1, 7'h56, 1, 1, 8'd1, 0);
    tbl[10] = mkv(0, 7'h00, 0, 1, 0,  0, 7'h56, 1, 1, 8'd2, 0);
    tbl[11] = mkv(0, 7'h00, 0, 0, 0,  0, 7'h56, 1, 0, 8'd2, 0);
    tbl[12] = mkv(1, 7'h11, 0, 0, 0,  0, 7'h56, 1, 1, 8'd2, 0);
    tbl[13] = mkv(1, 7'h4A, 0, 0, 0,  1, 7'h11, 1, 1, 8'd2, 0);
    tbl[14] = mkv(0, 7'h00, 0, 1, 0,  1, 7'h11, 1, 1, 8'd2, 0);
    tbl[15] = mkv(0, 7'h00, 1, 0, 0,  0, 7'h11, 1, 1, 8'd3, 0);
    tbl[16] = mkv(0, 7'h00, 0, 0, 0,  1, 7'h4A, 1, 1, 8'd3, 0);
    tbl[17] = mkv(0, 7'h00, 1, 1, 0,  0, 7'h4A, 1, 1, 8'd4, 0);
    tbl[18] = mkv(0, 7'h00, 0, 0, 0,  0, 7'h4A, 1, 0, 8'd4, 0);

    // Reset state
    #12;
    chk("rst.in_valid", 32'(bus.in_valid), 32'd0);
    chk("rst.data_out", 32'(bus.data_out), 32'd0);
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done_cnt", 32'(bus.done_cnt), 32'd0);
    chk("rst.timeout_err", 32'(bus.timeout_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 19; i++) begin
      bus.req_valid        = tbl[i].rv;
      bus.req_data         = tbl[i].rd;
      bus.handshake_slave1 = tbl[i].h1;
      bus.handshake_slave2 = tbl[i].h2;
      bus.clr_err          = tbl[i].clr;
      step();
      chk($sformatf("vec%0d.in_valid", i), 32'(bus.in_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d.data_out", i), 32'(bus.data_out), 32'(tbl[i].ed));
      chk($sformatf("vec%0d.req_ready", i), 32'(bus.req_ready), 32'(tbl[i].erdy));
      chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(tbl[i].ebusy));
      chk($sformatf("vec%0d.done_cnt", i), 32'(bus.done_cnt), 32'(tbl[i].edone));
      chk($sformatf("vec%0d.timeout_err", i), 32'(bus.timeout_err), 32'(tbl[i].eerr));
    end
    idle_in();

    // Full FIFO with stalled slave: 4 accepted, 5th refused.
    for (int k = 0; k < 4; k++) begin
      push1(7'(k + 1));
      chk($sformatf("full.rdy_after_push%0d", k + 1), 32'(bus.req_ready), (k == 3) ? 32'd0 : 32'd1);
    end
    bus.req_valid = 1'b1;
    bus.req_data  = 7'h05;
    step();
    bus.req_valid = 1'b0;
    chk("full.rdy_5th", 32'(bus.req_ready), 32'd0);
    chk("full.head_sent", 32'(bus.data_out), 32'h01);
    bus.handshake_slave1 = 1'b1;
    step();
    bus.handshake_slave1 = 1'b0;
    chk("full.rdy_after_retire", 32'(bus.req_ready), 32'd1);
    chk("full.in_valid_gap", 32'(bus.in_valid), 32'd0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("full.send%0d.in_valid", k), 32'(bus.in_valid), 32'd1);
      chk($sformatf("full.send%0d.data_out", k), 32'(bus.data_out), 32'(k + 1));
      bus.handshake_slave1 = 1'b1;
      step();
      bus.handshake_slave1 = 1'b0;
    end
    step();
    chk("full.no_5th.in_valid", 32'(bus.in_valid), 32'd0);
    chk("full.no_5th.busy", 32'(bus.busy), 32'd0);
    chk("full.done_cnt", 32'(bus.done_cnt), 32'd8);

    // Timeout: 16 SEND cycles without handshake, then next entry after one GAP.
    push1(7'h1F);
    push1(7'h20);
    chk("to.enter.in_valid", 32'(bus.in_valid), 32'd1);
    repeat (15) step();
    chk("to.cycle15.in_valid", 32'(bus.in_valid), 32'd1);
    chk("to.cycle15.err", 32'(bus.timeout_err), 32'd0);
    step();
    chk("to.drop.in_valid", 32'(bus.in_valid), 32'd0);
    chk("to.drop.err", 32'(bus.timeout_err), 32'd1);
    chk("to.drop.done_cnt", 32'(bus.done_cnt), 32'd8);
    step();
    chk("to.next.in_valid", 32'(bus.in_valid), 32'd1);
    chk("to.next.data_out", 32'(bus.data_out), 32'h20);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("to.clr.err", 32'(bus.timeout_err), 32'd0);
    bus.handshake_slave1 = 1'b1;
    step();
    bus.handshake_slave1 = 1'b0;
    chk("to.next.done_cnt", 32'(bus.done_cnt), 32'd9);
    step();

    // Boundary: handshake on the 16th SEND cycle wins over timeout.
    push1(7'h33);
    step();
    chk("bnd.enter.in_valid", 32'(bus.in_valid), 32'd1);
    repeat (15) step();
    bus.handshake_slave1 = 1'b1;
    step();
    bus.handshake_slave1 = 1'b0;
    chk("bnd.done_cnt", 32'(bus.done_cnt), 32'd10);
    chk("bnd.err", 32'(bus.timeout_err), 32'd0);
    chk("bnd.in_valid", 32'(bus.in_valid), 32'd0);
    step();

    // Timeout set in the same cycle as clr_err: set wins.
    push1(7'h2C);
    step();
    repeat (15) step();
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("prio.err_set_wins", 32'(bus.timeout_err), 32'd1);
    chk("prio.done_cnt", 32'(bus.done_cnt), 32'd10);
    step();
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("prio.err_cleared", 32'(bus.timeout_err), 32'd0);

    // 256 transactions: done_cnt wraps through 255 -> 0 and returns to 10.
    exp_done = 8'd10;
    for (int i = 0; i < 256; i++) begin
      push1(7'(i & 63));
      step();
      bus.handshake_slave1 = 1'b1;
      step();
      bus.handshake_slave1 = 1'b0;
      step();
      exp_done = exp_done + 8'd1;
      chk($sformatf("wrap.t%0d.done_cnt", i), 32'(bus.done_cnt), 32'(exp_done));
    end
    chk("wrap.final", 32'(bus.done_cnt), 32'd10);

    // Reset mid-SEND with 3 entries queued.
    push1(7'h01);
    push1(7'h02);
    push1(7'h03);
    chk("rst2.pre.in_valid", 32'(bus.in_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2.in_valid", 32'(bus.in_valid), 32'd0);
    chk("rst2.done_cnt", 32'(bus.done_cnt), 32'd0);
    chk("rst2.busy", 32'(bus.busy), 32'd0);
    chk("rst2.req_ready", 32'(bus.req_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rst2.post%0d.in_valid", i), 32'(bus.in_valid), 32'd0);
    end
    chk("rst2.post.busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
